// File: rtl/panel_pkg.sv
// Shared types and constants for the LED panel column scanner.
// Mode encoding, scan FSM states and panel geometry.
package panel_pkg;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 5;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// Column slot prescaler and column counter for the panel scanner.
// Counts only while enabled; clear forces both counters to zero.
module scan_timebase
  import panel_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  output logic [2:0]                 col_idx,
  output logic [cnt_w(SCAN_DIV)-1:0] presc,
  output logic                       slot_end,
  output logic                       frame_wrap
);

  localparam int PW = cnt_w(SCAN_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0] C_LAST = 3'(NUM_COLS - 1);

  assign slot_end   = en && !clr && (presc == P_LAST);
  assign frame_wrap = slot_end && (col_idx == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      col_idx <= '0;
    end else if (clr) begin
      presc   <= '0;
      col_idx <= '0;
    end else if (en) begin
      if (presc == P_LAST) begin
        presc   <= '0;
        col_idx <= (col_idx == C_LAST) ? 3'd0 : col_idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/panel_scan_controller.sv
// 7-column LED panel scan controller with scroll strobes.
// Define PANEL_GHOST_BLANK_EN to blank columns at the end of each slot.
module panel_scan_controller
  import panel_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int FRAMES_PER_STEP = 8,
  parameter int BLANK_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic [2:0] col_idx,
  output logic [6:0] col_n,
  output logic       load_stb,
  output logic       shift_stb,
  output logic       shift_dir,
  output logic       frame_stb
);

  localparam int PW = cnt_w(SCAN_DIV);
  localparam int FW = cnt_w(FRAMES_PER_STEP);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_STEP - 1);

`ifdef PANEL_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  // Slot position from which the column is dark.
  localparam int BLANK_FROM =
    GHOST ? SCAN_DIV - BLANK_CYCLES : SCAN_DIV;

  state_e        state;
  mode_e         mode_q;
  logic [FW-1:0] fcnt;
  logic [PW-1:0] presc;
  logic          run;
  logic          slot_end;
  logic          frame_wrap;

  assign run = (state == ST_RUN) && (mode_q != MODE_OFF);

  scan_timebase #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run),
    .clr       (!run),
    .col_idx   (col_idx),
    .presc     (presc),
    .slot_end  (slot_end),
    .frame_wrap(frame_wrap)
  );

  always_comb begin
    col_n = '1;
    if (state == ST_RUN && int'(presc) < BLANK_FROM)
      col_n[col_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      mode_q    <= MODE_OFF;
      fcnt      <= '0;
      load_stb  <= 1'b0;
      shift_stb <= 1'b0;
      frame_stb <= 1'b0;
      shift_dir <= 1'b0;
    end else begin
      mode_q    <= mode_e'(mode);
      load_stb  <= 1'b0;
      shift_stb <= 1'b0;
      frame_stb <= 1'b0;
      unique case (state)
        ST_OFF: begin
          fcnt <= '0;
          if (mode_q != MODE_OFF) begin
            state     <= ST_LOAD;
            load_stb  <= 1'b1;
            shift_dir <= (mode_q == MODE_RIGHT);
          end
        end
        ST_LOAD: begin
          fcnt  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (mode_q == MODE_OFF) begin
            state <= ST_OFF;
            fcnt  <= '0;
          end else if (slot_end) begin
            // Mode changes are adopted only on frame boundaries.
            if (frame_wrap) begin
              frame_stb <= 1'b1;
              shift_dir <= (mode_q == MODE_RIGHT);
              if (fcnt == F_LAST) begin
                fcnt      <= '0;
                shift_stb <= (mode_q == MODE_LEFT) ||
                             (mode_q == MODE_RIGHT);
              end else begin
                fcnt <= fcnt + FW'(1);
              end
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_scan_controller.sv
// Randomised self-checking bench for panel_scan_controller.
// Reference model works from elapsed run time, not from counters.
module tb_panel_scan_controller;

  localparam int SD    = 4;
  localparam int FPS   = 2;
  localparam int BL    = 1;
  localparam int FRAME = 7 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] col_idx;
  logic [6:0] col_n;
  logic       load_stb, shift_stb, shift_dir, frame_stb;

  always #5 clk = ~clk;

  panel_scan_controller #(
    .SCAN_DIV(SD),
    .FRAMES_PER_STEP(FPS),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .col_idx  (col_idx),
    .col_n    (col_n),
    .load_stb (load_stb),
    .shift_stb(shift_stb),
    .shift_dir(shift_dir),
    .frame_stb(frame_stb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 off, 1 load, 2 running for t cycles.
  int   cyc, ph, mq, t;
  logic m_dir, m_load, m_frame, m_shift;

  int load_q[$];
  int frame_q[$];
  int fdir_q[$];
  int shift_q[$];

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int old;
    if (!rst_n) begin
      cyc = 0; ph = 0; mq = 0; t = 0;
      m_dir = 0; m_load = 0; m_frame = 0; m_shift = 0;
    end else begin
      old = mq;
      mq = int'(mode);
      cyc++;
      m_load = 0; m_frame = 0; m_shift = 0;
      case (ph)
        0: if (old != 0) begin
          ph = 1; m_load = 1; m_dir = (old == 2);
        end
        1: begin ph = 2; t = 0; end
        default: if (old == 0) ph = 0;
        else begin
          t++;
          if (t % FRAME == 0) begin
            m_frame = 1;
            m_dir = (old == 2);
            if ((t / FRAME) % FPS == 0 && (old == 1 || old == 2))
              m_shift = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [6:0] ec;
    int col;
    col = (ph == 2) ? (t / SD) % 7 : 0;
    ec = '1;
    if (ph == 2) begin
      ec[col] = 1'b0;
`ifdef PANEL_GHOST_BLANK_EN
      if (t % SD >= SD - BL) ec = '1;
`endif
    end
    check("col_idx", col_idx, col);
    check("col_n", col_n, ec);
    check("load_stb", load_stb, m_load);
    check("frame_stb", frame_stb, m_frame);
    check("shift_stb", shift_stb, m_shift);
    check("shift_dir", shift_dir, m_dir);
    if (rst_n) begin
      if (load_stb) load_q.push_back(cyc);
      if (frame_stb) begin
        frame_q.push_back(cyc);
        fdir_q.push_back(int'(shift_dir));
      end
      if (shift_stb) shift_q.push_back(cyc);
    end
  end

  task automatic wait_col(input int c);
    int k;
    k = 0;
    while (col_idx != 3'(c) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_col_timeout", k < 100, 1);
  endtask

  initial begin
    int nl, nf, ns, k0;
    mode = 2'b01;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Steady scroll left from reset release.
    repeat (130) @(posedge clk);
    check("first_load_cycle",
          load_q.size() > 0 ? load_q[0] : -1, 2);
    check("load_count_a", load_q.size(), 1);
    check("frame0_cycle",
          frame_q.size() > 0 ? frame_q[0] : -1, 31);
    check("frame_spacing",
          frame_q.size() > 1 ? frame_q[1] - frame_q[0] : -1, 28);
    check("shift0_cycle",
          shift_q.size() > 0 ? shift_q[0] : -1, 59);
    check("shift_spacing",
          shift_q.size() > 1 ? shift_q[1] - shift_q[0] : -1, 56);
    check("shift0_dir",
          fdir_q.size() > 1 ? fdir_q[1] : -1, 0);

    // Left to right mid-frame: direction flips at next frame.
    nl = load_q.size(); nf = frame_q.size();
    #1 mode = 2'b10;
    repeat (60) @(posedge clk);
    check("no_reload_b", load_q.size() - nl, 0);
    check("dir_after_frame",
          fdir_q.size() > nf ? fdir_q[nf] : -1, 1);

    // Static hold: frames continue, no shifts.
    nf = frame_q.size(); ns = shift_q.size();
    #1 mode = 2'b11;
    repeat (200) @(posedge clk);
    check("hold_no_shift", shift_q.size() - ns, 0);
    check("hold_frames",
          (frame_q.size() - nf == 7) || (frame_q.size() - nf == 8), 1);

    // Off in the middle of column 3, then back on.
    @(posedge clk); #1 mode = 2'b01;
    @(negedge clk);
    wait_col(3);
    @(posedge clk); #1 mode = 2'b00;
    repeat (10) @(negedge clk);
    check("off_col_n", col_n, 7'h7f);
    check("off_col_idx", col_idx, 0);
    nl = load_q.size();
    @(posedge clk); #1 mode = 2'b01; k0 = cyc;
    repeat (12) @(posedge clk);
    check("reload_count", load_q.size() - nl, 1);
    check("reload_cycle",
          load_q.size() > nl ? load_q[nl] - k0 : -1, 2);

    // Async reset mid-frame while scrolling right.
    #1 mode = 2'b10;
    repeat (70) @(posedge clk);
    @(negedge clk);
    wait_col(4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_col_idx", col_idx, 0);
    check("rst_col_n", col_n, 7'h7f);
    check("rst_dir", shift_dir, 0);
    check("rst_strobes", {load_stb, shift_stb, frame_stb}, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Random mode sequences with occasional async resets.
    for (int s = 0; s < 40; s++) begin
      @(posedge clk); #1 mode = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 120)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) begin
        #2 rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
